msx_vdp_bus_bridge: RTL and testbench

MSX_VDP_BUS_BRIDGE -- requirements
Module: msx_vdp_bus_bridge

---
 rtl/tang20cart_pkg.sv | 14 +
 rtl/msx_bus_sync.sv | 31 +++
 rtl/msx_vdp_bus_bridge.sv | 160 ++++++++++++++++
 tb/tb_msx_vdp_bus_bridge.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tang20cart_pkg.sv
// Shared definitions for the Tang20 cartridge logic: bridge FSM encoding and timing defaults.
package tang20cart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DRIVE   = 2'd2,
    ST_RELEASE = 2'd3
  } bridge_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int TO_CNT_W           = 8;

endpackage

// File: rtl/msx_bus_sync.sv
// Two-flop synchronizer for a group of asynchronous cartridge signals, plus a
// per-bit 2-sample agreement flag so callers can reject single-cycle glitches.
module msx_bus_sync #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] stable_o
);

  logic [W-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_o      = s2_q;
  assign stable_o = ~(s2_q ^ s3_q);

endmodule

// File: rtl/msx_vdp_bus_bridge.sv
// Bridges asynchronous MSX cartridge I/O cycles onto the synchronous VDP req/ack port,
// stretching the MSX cycle with twait and aborting stalled requests after a timeout.
module msx_vdp_bus_bridge
  import tang20cart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       n_ce,
  input  logic       n_trd,
  input  logic       n_twr,
  input  logic [1:0] ta,
  input  logic [7:0] td_in,
  output logic [7:0] td_out,
  output logic       td_oe,
  output logic       twait,
  output logic       vdp_req,
  input  logic       vdp_ack,
  output logic       vdp_wr,
  output logic [1:0] vdp_adr,
  output logic [7:0] vdp_dbo,
  input  logic [7:0] vdp_dbi,
  output logic       timeout_err
);

  localparam logic [TO_CNT_W-1:0] TO_LIM = TO_CNT_W'(TIMEOUT_CYCLES);

  logic [4:0] ctl_s, ctl_stb;
  logic [7:0] td_s, td_stb;

  msx_bus_sync #(.W(5), .RST_VAL(5'b11100)) u_sync_ctl (
    .clk      (clk),
    .n_reset  (n_reset),
    .d_i      ({n_ce, n_trd, n_twr, ta}),
    .q_o      (ctl_s),
    .stable_o (ctl_stb)
  );

  msx_bus_sync #(.W(8), .RST_VAL(8'h00)) u_sync_td (
    .clk      (clk),
    .n_reset  (n_reset),
    .d_i      (td_in),
    .q_o      (td_s),
    .stable_o (td_stb)
  );

  logic       ce_s, trd_s, twr_s;
  logic [1:0] ta_s;
  logic       rd_acc, wr_acc, bus_held, bus_free, drive_ok;

  assign ce_s  = ctl_s[4];
  assign trd_s = ctl_s[3];
  assign twr_s = ctl_s[2];
  assign ta_s  = ctl_s[1:0];

  // Write data must also have settled before it is latched for the VDP.
  assign rd_acc   = (&ctl_stb) && !ce_s && !trd_s && twr_s;
  assign wr_acc   = (&ctl_stb) && (&td_stb) && !ce_s && trd_s && !twr_s;
  assign bus_free = ce_s && trd_s && twr_s;

  bridge_state_e       state_q, state_d;
  logic                req_q, req_d;
  logic                wr_q, wr_d;
  logic [1:0]          adr_q, adr_d;
  logic [7:0]          dbo_q, dbo_d;
  logic [7:0]          tdo_q, tdo_d;
  logic                terr_q, terr_d;
  logic                abort_q, abort_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  assign bus_held = !ce_s && (wr_q ? !twr_s : !trd_s);
  // A read result is only presented if the MSX never let go of the cycle.
  assign drive_ok = !wr_q && bus_held && !abort_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      adr_q   <= 2'd0;
      dbo_q   <= 8'h00;
      tdo_q   <= 8'h00;
      terr_q  <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      adr_q   <= adr_d;
      dbo_q   <= dbo_d;
      tdo_q   <= tdo_d;
      terr_q  <= terr_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_d    = wr_q;
    adr_d   = adr_q;
    dbo_d   = dbo_q;
    tdo_d   = tdo_q;
    terr_d  = 1'b0;
    abort_d = abort_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_acc || wr_acc) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          wr_d    = wr_acc;
          adr_d   = ta_s;
          if (wr_acc) dbo_d = td_s;
          cnt_d   = '0;
          abort_d = 1'b0;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus_held) abort_d = 1'b1;
        if (vdp_ack) begin
          req_d = 1'b0;
          if (drive_ok) begin
            tdo_d   = vdp_dbi;
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_RELEASE;
          end
        end else if (cnt_q == TO_LIM) begin
          req_d   = 1'b0;
          terr_d  = 1'b1;
          tdo_d   = 8'hFF;
          state_d = drive_ok ? ST_DRIVE : ST_RELEASE;
        end
      end
      ST_DRIVE: begin
        if (ce_s || trd_s) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (bus_free) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output enable is gated combinationally so it drops the cycle the release is seen.
  assign td_oe       = (state_q == ST_DRIVE) && !ce_s && !trd_s;
  assign td_out      = tdo_q;
  assign twait       = req_q;
  assign vdp_req     = req_q;
  assign vdp_wr      = wr_q;
  assign vdp_adr     = adr_q;
  assign vdp_dbo     = dbo_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_msx_vdp_bus_bridge.sv
// Directed bench for msx_vdp_bus_bridge: write, read, timeout, glitch, abort and reset scenarios.
module tb_msx_vdp_bus_bridge;

  logic       clk;
  logic       n_reset;
  logic       n_ce, n_trd, n_twr;
  logic [1:0] ta;
  logic [7:0] td_in;
  logic [7:0] td_out;
  logic       td_oe, twait, vdp_req, vdp_ack, vdp_wr, timeout_err;
  logic [1:0] vdp_adr;
  logic [7:0] vdp_dbo, vdp_dbi;

  int checks;
  int errors;

  msx_vdp_bus_bridge #(.TIMEOUT_CYCLES(255)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .n_ce        (n_ce),
    .n_trd       (n_trd),
    .n_twr       (n_twr),
    .ta          (ta),
    .td_in       (td_in),
    .td_out      (td_out),
    .td_oe       (td_oe),
    .twait       (twait),
    .vdp_req     (vdp_req),
    .vdp_ack     (vdp_ack),
    .vdp_wr      (vdp_wr),
    .vdp_adr     (vdp_adr),
    .vdp_dbo     (vdp_dbo),
    .vdp_dbi     (vdp_dbi),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_req(output int cyc);
    cyc = 0;
    while (vdp_req !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic bus_idle();
    n_ce  = 1'b1;
    n_trd = 1'b1;
    n_twr = 1'b1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    bus_idle();
    ta = 2'd0; td_in = 8'h00; vdp_ack = 1'b0; vdp_dbi = 8'h00;
    #1;
    checks++;
    if ({vdp_req, vdp_wr, vdp_adr, vdp_dbo, td_out, td_oe, twait, timeout_err} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs req=%b wr=%b adr=%0d dbo=%h tdo=%h oe=%b tw=%b te=%b expected all 0",
               vdp_req, vdp_wr, vdp_adr, vdp_dbo, td_out, td_oe, twait, timeout_err);
    end
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (vdp_req !== 1'b0 || td_oe !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset req=%b oe=%b expected 0 0", vdp_req, td_oe);
    end
  endtask

  task automatic test_write();
    int  c;
    bit  stable;
    bit  rereq;
    @(negedge clk);
    ta = 2'd1; td_in = 8'h8F; n_ce = 1'b0; n_twr = 1'b0;
    wait_req(c);
    checks++;
    if (vdp_req !== 1'b1) begin
      errors++; $display("FAIL wr_req_raised got %b expected 1", vdp_req);
    end
    checks++;
    if (vdp_wr !== 1'b1 || vdp_adr !== 2'd1 || vdp_dbo !== 8'h8F || twait !== 1'b1) begin
      errors++;
      $display("FAIL wr_fields wr=%b adr=%0d dbo=%h tw=%b expected 1 1 8f 1", vdp_wr, vdp_adr, vdp_dbo, twait);
    end
    td_in = 8'h00;
    stable = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (vdp_req !== 1'b1 || vdp_wr !== 1'b1 || vdp_adr !== 2'd1 || vdp_dbo !== 8'h8F || twait !== 1'b1)
        stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++; $display("FAIL wr_hold_stable got %b expected 1", stable);
    end
    @(negedge clk);
    vdp_ack = 1'b1;
    checks++;
    if (twait !== 1'b1) begin
      errors++; $display("FAIL wr_twait_at_ack got %b expected 1", twait);
    end
    @(negedge clk);
    vdp_ack = 1'b0;
    checks++;
    if (vdp_req !== 1'b0 || twait !== 1'b0) begin
      errors++; $display("FAIL wr_req_drop req=%b tw=%b expected 0 0", vdp_req, twait);
    end
    rereq = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (vdp_req !== 1'b0) rereq = 1'b1;
    end
    checks++;
    if (rereq !== 1'b0) begin
      errors++; $display("FAIL wr_no_restart_held got %b expected 0", rereq);
    end
    bus_idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_read();
    int c;
    int k;
    bit oe_ok;
    @(negedge clk);
    ta = 2'd0; n_ce = 1'b0; n_trd = 1'b0;
    wait_req(c);
    checks++;
    if (vdp_req !== 1'b1 || vdp_wr !== 1'b0 || vdp_adr !== 2'd0 || td_oe !== 1'b0) begin
      errors++;
      $display("FAIL rd_req req=%b wr=%b adr=%0d oe=%b expected 1 0 0 0", vdp_req, vdp_wr, vdp_adr, td_oe);
    end
    repeat (3) @(negedge clk);
    vdp_dbi = 8'h5A; vdp_ack = 1'b1;
    @(negedge clk);
    vdp_ack = 1'b0; vdp_dbi = 8'h00;
    checks++;
    if (td_out !== 8'h5A || td_oe !== 1'b1 || vdp_req !== 1'b0) begin
      errors++;
      $display("FAIL rd_data tdo=%h oe=%b req=%b expected 5a 1 0", td_out, td_oe, vdp_req);
    end
    oe_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (td_oe !== 1'b1 || td_out !== 8'h5A) oe_ok = 1'b0;
    end
    checks++;
    if (oe_ok !== 1'b1) begin
      errors++; $display("FAIL rd_oe_hold got %b expected 1", oe_ok);
    end
    n_trd = 1'b1;
    k = 0;
    while (td_oe !== 1'b0 && k < 6) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (td_oe !== 1'b0 || k > 3) begin
      errors++; $display("FAIL rd_oe_release cycles=%0d oe=%b expected oe 0 within 3", k, td_oe);
    end
    bus_idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    int c;
    int at;
    int pulses;
    @(negedge clk);
    ta = 2'd2; n_ce = 1'b0; n_trd = 1'b0;
    wait_req(c);
    checks++;
    if (vdp_req !== 1'b1) begin
      errors++; $display("FAIL to_req_raised got %b expected 1", vdp_req);
    end
    at = 0;
    pulses = 0;
    for (int i = 1; i <= 300 && at == 0; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin
        at = i;
        pulses++;
      end
    end
    checks++;
    if (at < 250 || at > 260) begin
      errors++; $display("FAIL to_latency got %0d expected 250..260", at);
    end
    checks++;
    if (twait !== 1'b0 || vdp_req !== 1'b0 || td_out !== 8'hFF || td_oe !== 1'b1) begin
      errors++;
      $display("FAIL to_state tw=%b req=%b tdo=%h oe=%b expected 0 0 ff 1", twait, vdp_req, td_out, td_oe);
    end
    repeat (20) begin
      @(negedge clk);
      if (timeout_err === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL to_pulse_count got %0d expected 1", pulses);
    end
    bus_idle();
    repeat (5) @(negedge clk);
    checks++;
    if (td_oe !== 1'b0) begin
      errors++; $display("FAIL to_oe_off got %b expected 0", td_oe);
    end
  endtask

  task automatic test_glitch();
    bit seen;
    bit side;
    @(negedge clk);
    ta = 2'd3; td_in = 8'h11; n_ce = 1'b0; n_trd = 1'b0; n_twr = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (vdp_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL both_strobes_req got %b expected 0", seen);
    end
    bus_idle();
    repeat (4) @(negedge clk);
    n_ce = 1'b0;
    repeat (4) @(negedge clk);
    n_twr = 1'b0;
    @(negedge clk);
    n_twr = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (vdp_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL twr_glitch_req got %b expected 0", seen);
    end
    bus_idle();
    repeat (3) @(negedge clk);
    vdp_ack = 1'b1; vdp_dbi = 8'h77;
    @(negedge clk);
    vdp_ack = 1'b0;
    side = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (vdp_req !== 1'b0 || td_oe !== 1'b0 || timeout_err !== 1'b0 || td_out === 8'h77) side = 1'b1;
    end
    checks++;
    if (side !== 1'b0) begin
      errors++; $display("FAIL stray_ack_effect got %b expected 0", side);
    end
  endtask

  task automatic test_abort();
    int c;
    bit oe_seen;
    @(negedge clk);
    ta = 2'd1; n_ce = 1'b0; n_trd = 1'b0;
    wait_req(c);
    checks++;
    if (vdp_req !== 1'b1) begin
      errors++; $display("FAIL ab_req_raised got %b expected 1", vdp_req);
    end
    oe_seen = 1'b0;
    repeat (2) @(negedge clk);
    bus_idle();
    repeat (8) begin
      @(negedge clk);
      if (td_oe !== 1'b0) oe_seen = 1'b1;
    end
    checks++;
    if (vdp_req !== 1'b1) begin
      errors++; $display("FAIL ab_req_held got %b expected 1", vdp_req);
    end
    vdp_dbi = 8'h33; vdp_ack = 1'b1;
    @(negedge clk);
    vdp_ack = 1'b0;
    checks++;
    if (vdp_req !== 1'b0) begin
      errors++; $display("FAIL ab_req_drop got %b expected 0", vdp_req);
    end
    repeat (10) begin
      @(negedge clk);
      if (td_oe !== 1'b0) oe_seen = 1'b1;
    end
    checks++;
    if (oe_seen !== 1'b0) begin
      errors++; $display("FAIL ab_oe_seen got %b expected 0", oe_seen);
    end
    ta = 2'd3; td_in = 8'hC4; n_ce = 1'b0; n_twr = 1'b0;
    wait_req(c);
    checks++;
    if (vdp_req !== 1'b1 || vdp_wr !== 1'b1 || vdp_adr !== 2'd3 || vdp_dbo !== 8'hC4) begin
      errors++;
      $display("FAIL ab_next_access req=%b wr=%b adr=%0d dbo=%h expected 1 1 3 c4", vdp_req, vdp_wr, vdp_adr, vdp_dbo);
    end
    @(negedge clk);
    vdp_ack = 1'b1;
    @(negedge clk);
    vdp_ack = 1'b0;
    bus_idle();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int c;
    @(negedge clk);
    ta = 2'd2; td_in = 8'h11; n_ce = 1'b0; n_twr = 1'b0;
    wait_req(c);
    checks++;
    if (vdp_req !== 1'b1) begin
      errors++; $display("FAIL rm_req_raised got %b expected 1", vdp_req);
    end
    #2 n_reset = 1'b0;
    #1;
    checks++;
    if ({vdp_req, vdp_wr, vdp_adr, vdp_dbo, td_out, td_oe, twait, timeout_err} !== 23'd0) begin
      errors++;
      $display("FAIL rm_outputs req=%b wr=%b adr=%0d dbo=%h tdo=%h oe=%b tw=%b te=%b expected all 0",
               vdp_req, vdp_wr, vdp_adr, vdp_dbo, td_out, td_oe, twait, timeout_err);
    end
    bus_idle();
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    ta = 2'd1; td_in = 8'hA5; n_ce = 1'b0; n_twr = 1'b0;
    wait_req(c);
    checks++;
    if (vdp_req !== 1'b1 || vdp_wr !== 1'b1 || vdp_adr !== 2'd1 || vdp_dbo !== 8'hA5) begin
      errors++;
      $display("FAIL rm_fresh_write req=%b wr=%b adr=%0d dbo=%h expected 1 1 1 a5", vdp_req, vdp_wr, vdp_adr, vdp_dbo);
    end
    @(negedge clk);
    vdp_ack = 1'b1;
    @(negedge clk);
    vdp_ack = 1'b0;
    checks++;
    if (vdp_req !== 1'b0 || twait !== 1'b0) begin
      errors++; $display("FAIL rm_fresh_done req=%b tw=%b expected 0 0", vdp_req, twait);
    end
    bus_idle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_glitch();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
